// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared op encodings, FSM states and chain seed helper
// for the digit-serial ALU execute unit.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_OR    = 3'b010,
    ALU_AND   = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_EQ    = 3'b101,
    ALU_GT    = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROT,
    DONE
  } state_e;

  // Seed of the serial flag chain: sub needs the +1,
  // and-reduce starts from all-ones.
  function automatic logic carry_seed(alu_op_e op);
    return (op == ALU_SUB) || (op == ALU_AND);
  endfunction

endpackage

// File: rtl/seq_alu_digit.sv
// seq_alu_digit: combinational DIGIT-bit ALU slice.
// Ports: op, digit_a/b, cin, eq_in, gt_in -> digit_res, cout, eq_out, gt_out.
module seq_alu_digit
  import seq_alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  alu_op_e          op,
  input  logic [DIGIT-1:0] digit_a,
  input  logic [DIGIT-1:0] digit_b,
  input  logic             cin,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic [DIGIT-1:0] digit_res,
  output logic             cout,
  output logic             eq_out,
  output logic             gt_out
);

  logic [DIGIT-1:0] bx;
  logic [DIGIT:0]   sum;

  always_comb begin
    bx = (op == ALU_SUB) ? ~digit_b : digit_b;
    sum = {1'b0, digit_a} + {1'b0, bx}
        + {{DIGIT{1'b0}}, cin};
    eq_out = eq_in & (digit_a == digit_b);
    // more significant digits arrive later and override
    gt_out = (digit_a != digit_b)
           ? (digit_a > digit_b) : gt_in;
    digit_res = digit_a;
    cout = 1'b0;
    // cout carries the running flag for every op
    unique case (op)
      ALU_ADD, ALU_SUB: begin
        digit_res = sum[DIGIT-1:0];
        cout = sum[DIGIT];
      end
      ALU_OR: begin
        digit_res = digit_a | digit_b;
        cout = cin | (|digit_a);
      end
      ALU_AND: begin
        digit_res = digit_a & digit_b;
        cout = cin & (&digit_a);
      end
      ALU_XOR: begin
        digit_res = digit_a ^ digit_b;
        cout = cin ^ (^digit_a);
      end
      ALU_EQ: cout = eq_out;
      ALU_GT: cout = gt_out;
      ALU_PASSB: begin
        digit_res = digit_b;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: digit-serial ALU with post-op funnel rotate, start/done handshake.
// Ports: clk, rst_n, start, op, a, b, rot -> busy, done, result, carry_out.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1,
  localparam int ROT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [ROT_W-1:0] rot,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("seq_alu: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] arot_q, arot_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_op_e          op_q, op_d;
  logic [ROT_W-1:0] rot_q, rot_d;
  logic             c_q, c_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             carry_q, carry_d;
  logic             accept;

  logic [DIGIT-1:0] dres;
  logic             dcout, deq, dgt;

  seq_alu_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .op       (op_q),
    .digit_a  (a_q[DIGIT-1:0]),
    .digit_b  (b_q[DIGIT-1:0]),
    .cin      (c_q),
    .eq_in    (eq_q),
    .gt_in    (gt_q),
    .digit_res(dres),
    .cout     (dcout),
    .eq_out   (deq),
    .gt_out   (dgt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    arot_d   = arot_q;
    work_d   = work_q;
    result_d = result_q;
    op_d     = op_q;
    rot_d    = rot_q;
    c_d      = c_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    carry_d  = carry_q;
    accept   = start
             && (state_q == IDLE || state_q == DONE);

    unique case (state_q)
      IDLE: ;
      CALC: begin
        a_d = a_q >> DIGIT;
        b_d = b_q >> DIGIT;
        // result digits enter at the top, LSB digit ends at bit 0
        work_d = work_q >> DIGIT;
        work_d[WIDTH-1 -: DIGIT] = dres;
        c_d  = dcout;
        eq_d = deq;
        gt_d = dgt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          cnt_d = '0;
          if (rot_q != '0) begin
            state_d = ROT;
          end else begin
            state_d  = DONE;
            result_d = work_d;
            carry_d  = dcout;
          end
        end
      end
      ROT: begin
        // funnel in the original a, MSB first
        work_d = {work_q[WIDTH-2:0], arot_q[WIDTH-1]};
        arot_d = arot_q << 1;
        cnt_d = cnt_q + CW'(1);
        if ((cnt_q + CW'(1)) == CW'(rot_q)) begin
          cnt_d    = '0;
          state_d  = DONE;
          result_d = work_d;
          carry_d  = c_q;
        end
      end
      DONE: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = CALC;
      cnt_d   = '0;
      a_d     = a;
      b_d     = b;
      arot_d  = a;
      work_d  = '0;
      op_d    = alu_op_e'(op);
      rot_d   = rot;
      c_d     = carry_seed(alu_op_e'(op));
      eq_d    = 1'b1;
      gt_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      arot_q   <= '0;
      work_q   <= '0;
      result_q <= '0;
      op_q     <= ALU_ADD;
      rot_q    <= '0;
      c_q      <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      arot_q   <= arot_d;
      work_q   <= work_d;
      result_q <= result_d;
      op_q     <= op_d;
      rot_q    <= rot_d;
      c_q      <= c_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      carry_q  <= carry_d;
    end
  end

  assign busy      = (state_q == CALC) || (state_q == ROT);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule
